// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard unit: forwarding selects, load-use/branch stall-flush, and memory-wait FSM with timeout.
// Optional macro HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1d,
  input  logic [4:0] rs2d,
  input  logic [4:0] rs1e,
  input  logic [4:0] rs2e,
  input  logic [4:0] rde,
  input  logic [1:0] result_src_e,
  input  logic       pc_src_e,
  input  logic [4:0] rdm,
  input  logic       reg_write_m,
  input  logic       mem_req_m,
  input  logic       mem_ready,
  input  logic [4:0] rdw,
  input  logic       reg_write_w,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
`ifdef HAZARD_PERF_EN
  output logic       mem_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`else
  output logic       mem_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          mem_stall;
  logic          full_stall;
  logic          load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    logic [1:0] sel;
    sel = 2'b00;
    if (wm && rm == rs && rm != 5'd0)      sel = 2'b10;
    else if (ww && rw == rs && rw != 5'd0) sel = 2'b01;
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1e, reg_write_m, rdm, reg_write_w, rdw);
  assign forward_b_e = fwd_sel(rs2e, reg_write_m, rdm, reg_write_w, rdw);

  assign mem_stall  = mem_req_m & ~mem_ready;
  assign full_stall = (state == S_ERR) | mem_stall;
  assign load_use   = (result_src_e == 2'b01) && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));

  // A memory stall freezes the whole pipe, so E-stage hazards wait until it releases.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (full_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (mem_stall) begin
          state    <= S_WAIT;
          wait_cnt <= CW'(1);
        end
        S_WAIT: if (!mem_stall) begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end else if (wait_cnt == LAST_CNT) begin
          state   <= S_ERR;
          mem_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        S_ERR:   mem_err <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_f | stall_d | stall_e | stall_m) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_d | flush_e)                     perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cases plus random traffic against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] result_src_e;
  logic       pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .rdm(rdm), .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .rdw(rdw), .reg_write_w(reg_write_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
`ifdef HAZARD_PERF_EN
    .mem_err(mem_err), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
    .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: consecutive memory-stall cycles seen, sticky error, perf tallies.
  int consec;
  bit err;
  int ref_stalls, ref_flushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (reg_write_m && rdm == rs) return 2'b10;
    if (reg_write_w && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {fa, fb, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err}
  function automatic logic [11:0] ref_outs();
    bit memw, lu;
    logic [3:0] st;
    logic [2:0] fl;
    memw = err || (mem_req_m && !mem_ready);
    lu   = (result_src_e == 2'b01) && (rde != 0) && (rde == rs1d || rde == rs2d);
    st = 4'b0000;
    fl = 3'b000;
    if (memw)          begin st = 4'b1111; fl = 3'b001; end
    else if (pc_src_e) fl = 3'b110;
    else if (lu)       begin st = 4'b1100; fl = 3'b010; end
    return {ref_fwd(rs1e), ref_fwd(rs2e), st, fl, err};
  endfunction

  function automatic logic [11:0] obs_outs();
    return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_w, mem_err};
  endfunction

  task automatic clr();
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    result_src_e = 2'b00;
    {pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w} = '0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(input string tag);
    logic [11:0] e;
    #1;
    e = ref_outs();
    check(tag, {20'd0, obs_outs()}, {20'd0, e});
    @(posedge clk);
    if (|e[7:4]) ref_stalls++;
    if (|e[3:2]) ref_flushes++;
    if (!err) begin
      if (mem_req_m && !mem_ready) begin
        consec++;
        if (consec == TO) err = 1;
      end else begin
        consec = 0;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle, whatever the inputs are.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    consec = 0; err = 0; ref_stalls = 0; ref_flushes = 0;
    #1;
    check({tag, "_in_reset"}, {20'd0, obs_outs()}, {20'd0, ref_outs()});
    check({tag, "_err_clr"}, {31'd0, mem_err}, 32'd0);
    clr();
    #1;
    check({tag, "_idle"}, {20'd0, obs_outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    consec = 0; err = 0; ref_stalls = 0; ref_flushes = 0;
    #3;
    check("reset_state", {20'd0, obs_outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Forwarding priority and x0
    reg_write_m = 1; rdm = 5; reg_write_w = 1; rdw = 5; rs1e = 5;
    #1 check("fwd_m_pri", {30'd0, forward_a_e}, 32'h2);
    cycle("fwd_m");
    rdm = 0;
    #1 check("fwd_w", {30'd0, forward_a_e}, 32'h1);
    cycle("fwd_w_cyc");
    rdm = 0; rdw = 0; rs1e = 0; rs2e = 0;
    #1 check("fwd_x0", {28'd0, forward_a_e, forward_b_e}, 32'h0);
    cycle("fwd_x0_cyc");

    // Load-use, one bubble
    clr(); result_src_e = 2'b01; rde = 7; rs2d = 7;
    #1 check("lu_stall", {29'd0, stall_f, stall_d, flush_e}, 32'h7);
    cycle("lu_cyc");
    clr();
    cycle("lu_after");
    result_src_e = 2'b01; rde = 0; rs2d = 0;
    cycle("lu_x0");

    // Branch beats load-use
    clr(); result_src_e = 2'b01; rde = 9; rs1d = 9; pc_src_e = 1;
    #1 check("br_lu", {28'd0, flush_d, flush_e, stall_f, stall_d}, 32'hC);
    cycle("br_lu_cyc");

    // 3-cycle memory wait then completion
    clr(); mem_req_m = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) cycle($sformatf("mw_%0d", i));
    mem_ready = 1;
    #1 check("mw_release", {27'd0, stall_f, stall_d, stall_e, stall_m, flush_w}, 32'h0);
    cycle("mw_done");
    clr();
    cycle("mw_idle");

    // Timeout to sticky error, then reset
    mem_req_m = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) cycle($sformatf("to_%0d", i));
    #1 check("to_err_set", {31'd0, mem_err}, 32'd1);
    mem_req_m = 0;
    cycle("to_err_sticky");
    mem_req_m = 1;
    do_reset("to_rst");

`ifdef HAZARD_PERF_EN
    clr(); mem_req_m = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) cycle("pf_wait");
    mem_ready = 1;
    cycle("pf_rdy");
    clr(); pc_src_e = 1;
    cycle("pf_br");
    clr();
    #1;
    check("perf_stall", perf_stall_cnt, 32'd3);
    check("perf_flush", perf_flush_cnt, 32'd1);
    check("perf_stall_ref", perf_stall_cnt, ref_stalls);
    check("perf_flush_ref", perf_flush_cnt, ref_flushes);
    @(negedge clk);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
      rdw  = 5'($urandom_range(0, 3));
      result_src_e = 2'($urandom_range(0, 3));
      pc_src_e    = ($urandom_range(0, 3) == 0);
      reg_write_m = 1'($urandom);
      reg_write_w = 1'($urandom);
      mem_req_m   = ($urandom_range(0, 2) != 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      if (n % 80 == 79) do_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
